phaser_out_ctrl: RTL

- SYSCLK-domain control core for the write-path (output) phaser; the transmit-side counterpart of the read-path phaser.
- Holds the fine (6-bit) and coarse (3-bit) output delay settings and serves the counter load/read port.
- Generates the divided-clock enable (OCLKDIV_EN) with divider reset and edge-advance, and sequences OSERDESRST after reset.
- Sits between the PHY calibration logic and the OSERDES/output clock tree.

---
 rtl/phaser_out_pkg.sv | 18 +
 rtl/phaser_out_div.sv | 51 +++++
 rtl/phaser_out_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/phaser_out_pkg.sv
// Shared types and constants for the output-phaser control core.
package phaser_out_pkg;

   localparam int FINE_W     = 6;
   localparam int COARSE_W   = 3;
   localparam int TAP_W      = 9;
   localparam int DIV_W      = 4;
   localparam int HOLD_CNT_W = 8;

   localparam logic [FINE_W-1:0]   FINE_MAX   = 6'd63;
   localparam logic [COARSE_W-1:0] COARSE_MAX = 3'd7;

   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/phaser_out_div.sv
// Divided-clock enable generator: modulo-CLKOUT_DIV counter with
// synchronous divider reset and one-cycle phase advance.
module phaser_out_div
   import phaser_out_pkg::*;
#(
   parameter int CLKOUT_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic divide_rst,
   input  logic edge_adv,
   output logic div_en
);

   localparam int               SUM_W = DIV_W + 1;
   localparam logic [SUM_W-1:0] DIV_L = SUM_W'(CLKOUT_DIV);
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLKOUT_DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             div_en_q, div_en_d;
   logic [SUM_W-1:0] sum_raw;

   // Next count: +1 normally, +2 on advance (a divide-by-2 has no distinct
   // earlier phase, so advance degenerates to a normal step there).
   // The enable is compared against the next count so it lines up with cnt_q.
   always_comb begin
      sum_raw = {1'b0, cnt_q} + ((edge_adv && (CLKOUT_DIV > 2)) ? 5'd2 : 5'd1);
      if (divide_rst) begin
         cnt_d = '0;
      end else if (sum_raw >= DIV_L) begin
         cnt_d = DIV_W'(sum_raw - DIV_L);
      end else begin
         cnt_d = DIV_W'(sum_raw);
      end
      div_en_d = (cnt_d == LAST);
   end

   // Counter and enable registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         div_en_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_en_q <= div_en_d;
      end
   end

   assign div_en = div_en_q;

endmodule

// File: rtl/phaser_out_ctrl.sv
// Output-phaser SYSCLK control core: tap registers with saturating steps,
// counter load/read port, post-reset OSERDESRST sequencing, divider enable.
// Optional macro PHASER_OUT_STICKY_OVF_EN: overflow flags hold until a read
// or reset instead of pulsing for one cycle.
module phaser_out_ctrl
   import phaser_out_pkg::*;
#(
   parameter int CLKOUT_DIV         = 4,
   parameter int FINE_DELAY         = 0,
   parameter int COARSE_DELAY       = 0,
   parameter int EN_OSERDES_RST     = 1,
   parameter int OSERDES_RST_CYCLES = 8
) (
   input  logic             SYSCLK,
   input  logic             RST,
   input  logic             COUNTERLOADEN,
   input  logic [TAP_W-1:0] COUNTERLOADVAL,
   input  logic             COUNTERREADEN,
   output logic [TAP_W-1:0] COUNTERREADVAL,
   input  logic             FINEENABLE,
   input  logic             FINEINC,
   input  logic             COARSEENABLE,
   input  logic             COARSEINC,
   input  logic             DIVIDERST,
   input  logic             EDGEADV,
   output logic             FINEOVERFLOW,
   output logic             COARSEOVERFLOW,
   output logic             OCLKDIV_EN,
   output logic             OSERDESRST,
   output logic             BUSY
);

   if (CLKOUT_DIV < 2 || CLKOUT_DIV > 16) begin : g_bad_div
      $error("phaser_out_ctrl: CLKOUT_DIV must be 2..16");
   end
   if (FINE_DELAY < 0 || FINE_DELAY > 63) begin : g_bad_fine
      $error("phaser_out_ctrl: FINE_DELAY must be 0..63");
   end
   if (COARSE_DELAY < 0 || COARSE_DELAY > 7) begin : g_bad_coarse
      $error("phaser_out_ctrl: COARSE_DELAY must be 0..7");
   end
   if (OSERDES_RST_CYCLES < 1 || OSERDES_RST_CYCLES > 255) begin : g_bad_rst_cycles
      $error("phaser_out_ctrl: OSERDES_RST_CYCLES must be 1..255");
   end

   localparam logic [FINE_W-1:0]     FINE_RST   = FINE_W'(FINE_DELAY);
   localparam logic [COARSE_W-1:0]   COARSE_RST = COARSE_W'(COARSE_DELAY);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST  = HOLD_CNT_W'(OSERDES_RST_CYCLES - 1);
   localparam logic                  OSR_RST    = (EN_OSERDES_RST != 0);

   state_t                state_q, state_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [FINE_W-1:0]     fine_q, fine_d;
   logic [COARSE_W-1:0]   coarse_q, coarse_d;
   logic [TAP_W-1:0]      read_val_q, read_val_d;
   logic                  fine_ovf_q, fine_ovf_d;
   logic                  coarse_ovf_q, coarse_ovf_d;
   logic                  oserdes_rst_q, oserdes_rst_d;
   logic                  busy_q, busy_d;
   logic                  fine_evt, coarse_evt;

   // Next-state logic: HOLD times the OSERDES reset, RUN serves the tap port.
   // A load overrides any step in the same cycle and never flags overflow.
   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      fine_d        = fine_q;
      coarse_d      = coarse_q;
      read_val_d    = read_val_q;
      fine_ovf_d    = fine_ovf_q;
      coarse_ovf_d  = coarse_ovf_q;
      oserdes_rst_d = oserdes_rst_q;
      busy_d        = busy_q;
      fine_evt      = 1'b0;
      coarse_evt    = 1'b0;
      case (state_q)
         HOLD: begin
            if (EN_OSERDES_RST == 0 || hold_cnt_q == HOLD_LAST) begin
               state_d       = RUN;
               oserdes_rst_d = 1'b0;
               busy_d        = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         RUN: begin
            if (COUNTERREADEN) begin
               read_val_d = {coarse_q, fine_q};
            end
            if (COUNTERLOADEN) begin
               fine_d   = COUNTERLOADVAL[FINE_W-1:0];
               coarse_d = COUNTERLOADVAL[TAP_W-1:FINE_W];
            end else begin
               if (FINEENABLE) begin
                  if (FINEINC) begin
                     if (fine_q == FINE_MAX) fine_evt = 1'b1;
                     else                    fine_d   = fine_q + 6'd1;
                  end else begin
                     if (fine_q == '0) fine_evt = 1'b1;
                     else              fine_d   = fine_q - 6'd1;
                  end
               end
               if (COARSEENABLE) begin
                  if (COARSEINC) begin
                     if (coarse_q == COARSE_MAX) coarse_evt = 1'b1;
                     else                        coarse_d   = coarse_q + 3'd1;
                  end else begin
                     if (coarse_q == '0) coarse_evt = 1'b1;
                     else                coarse_d   = coarse_q - 3'd1;
                  end
               end
            end
`ifdef PHASER_OUT_STICKY_OVF_EN
            fine_ovf_d   = fine_evt   | (fine_ovf_q   & ~COUNTERREADEN);
            coarse_ovf_d = coarse_evt | (coarse_ovf_q & ~COUNTERREADEN);
`else
            fine_ovf_d   = fine_evt;
            coarse_ovf_d = coarse_evt;
`endif
         end
         default: state_d = HOLD;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state_q       <= HOLD;
         hold_cnt_q    <= '0;
         fine_q        <= FINE_RST;
         coarse_q      <= COARSE_RST;
         read_val_q    <= '0;
         fine_ovf_q    <= 1'b0;
         coarse_ovf_q  <= 1'b0;
         oserdes_rst_q <= OSR_RST;
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         fine_q        <= fine_d;
         coarse_q      <= coarse_d;
         read_val_q    <= read_val_d;
         fine_ovf_q    <= fine_ovf_d;
         coarse_ovf_q  <= coarse_ovf_d;
         oserdes_rst_q <= oserdes_rst_d;
         busy_q        <= busy_d;
      end
   end

   phaser_out_div #(
      .CLKOUT_DIV (CLKOUT_DIV)
   ) u_div (
      .clk        (SYSCLK),
      .rst        (RST),
      .divide_rst (DIVIDERST),
      .edge_adv   (EDGEADV),
      .div_en     (OCLKDIV_EN)
   );

   assign COUNTERREADVAL = read_val_q;
   assign FINEOVERFLOW   = fine_ovf_q;
   assign COARSEOVERFLOW = coarse_ovf_q;
   assign OSERDESRST     = oserdes_rst_q;
   assign BUSY           = busy_q;

endmodule
